// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: up to NREQ requesters share one write port.
// A single request writes one register. A paired request writes DataA to
// register 7 and then DataB to register 6 on the next cycle (PAIR2 state).
// Define REGFILE_ARB_RR_EN for round-robin arbitration. Without it, the
// lowest-index valid requester always wins.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic [NREQ-1:0]   ReqValid,
    input  logic [NREQ-1:0]   ReqPair,
    input  logic [NREQ*AW-1:0] ReqAddr,
    input  logic [NREQ*DW-1:0] ReqDataA,
    input  logic [NREQ*DW-1:0] ReqDataB,
    output logic [NREQ-1:0]   ReqReady,
    output logic              WrEn,
    output logic [AW-1:0]     WrAddr,
    output logic [DW-1:0]     WrData,
    output logic              Busy
);

    localparam logic [AW-1:0] PAIR_HI_ADDR = AW'(7);
    localparam logic [AW-1:0] PAIR_LO_ADDR = AW'(6);

    typedef enum logic {IDLE, PAIR2} state_t;

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic [DW-1:0]     datab_q, datab_d;

    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   accept;
    logic              arb_found;
    logic              sel_pair;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_a;
    logic [DW-1:0]     sel_b;

`ifdef REGFILE_ARB_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    // Round-robin winner: search from the pointer upward, then wrap to the bottom
    always_comb begin
        gnt       = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_found && ReqValid[i] && (i >= int'(ptr_q))) begin
                gnt[i]    = 1'b1;
                arb_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_found && ReqValid[i] && (i < int'(ptr_q))) begin
                gnt[i]    = 1'b1;
                arb_found = 1'b1;
            end
        end
    end

    // Pointer moves just past whichever requester was accepted
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: the lowest-index valid requester wins
    always_comb begin
        gnt       = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_found && ReqValid[i]) begin
                gnt[i]    = 1'b1;
                arb_found = 1'b1;
            end
        end
    end
`endif

    // Grants are offered only from IDLE and never while reset is held
    assign ReqReady = ((state_q == IDLE) && ResetN) ? gnt : '0;
    assign accept   = ReqValid & ReqReady;

    // Select the accepted requester's fields (accept is one-hot or zero)
    always_comb begin
        sel_pair = 1'b0;
        sel_addr = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                sel_pair = ReqPair[i];
                sel_addr = ReqAddr[i*AW +: AW];
                sel_a    = ReqDataA[i*DW +: DW];
                sel_b    = ReqDataB[i*DW +: DW];
            end
        end
    end

    // Next state and next write-port contents; address/data hold when idle
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        datab_d   = datab_q;
        case (state_q)
            IDLE: begin
                if (|accept) begin
                    wr_en_d = 1'b1;
                    if (sel_pair) begin
                        wr_addr_d = PAIR_HI_ADDR;
                        wr_data_d = sel_a;
                        datab_d   = sel_b;
                        state_d   = PAIR2;
                    end else begin
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_a;
                    end
                end
            end
            PAIR2: begin
                wr_en_d   = 1'b1;
                wr_addr_d = PAIR_LO_ADDR;
                wr_data_d = datab_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered write port
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Captured second-half data; only consumed after a pair is accepted
    always_ff @(posedge Clk) begin
        datab_q <= datab_d;
    end

    assign WrEn   = wr_en_q;
    assign WrAddr = wr_addr_q;
    assign WrData = wr_data_q;
    assign Busy   = (state_q == PAIR2);

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write requesters (0 = ALU, 1 = load, 2 = move/immediate).
REQ-002 SHALL have parameter AW, default 3, register address width.
REQ-003 SHALL have parameter DW, default 16, register data width.
REQ-004 SHALL have port Clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port ResetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ReqValid  input  NREQ  per-requester write request.
REQ-007 SHALL have port ReqPair  input  NREQ  request is a paired write: register 7 gets DataA, register 6 gets DataB.
REQ-008 SHALL have port ReqAddr  input  NREQ*AW  target register for single writes; slice i belongs to requester i.
REQ-009 SHALL have port ReqDataA  input  NREQ*DW  single-write data, or paired-write data for register 7.
REQ-010 SHALL have port ReqDataB  input  NREQ*DW  paired-write data for register 6; ignored for single writes.
REQ-011 SHALL have port ReqReady  output  NREQ  one-hot or zero accept strobe.
REQ-012 SHALL have port WrEn  output  1  register-file write enable.
REQ-013 SHALL have port WrAddr  output  AW  register-file write address.
REQ-014 SHALL have port WrData  output  DW  register-file write data.
REQ-015 SHALL have port Busy  output  1  high while in PAIR2 state.

Function
REQ-016 SHALL have two states: IDLE and PAIR2.
REQ-017 SHALL accept a transfer only when ReqValid[i] and ReqReady[i] are both high in the same cycle.
REQ-018 SHALL drive ReqReady combinationally, asserting at most one bit, and only in IDLE, only for the arbitration winner among valid requesters.
REQ-019 SHALL keep every ReqReady bit low in PAIR2.
REQ-020 SHALL register WrEn, WrAddr and WrData; a write appears exactly one cycle after acceptance.
REQ-021 SHALL, on an accepted single request, drive WrEn=1, WrAddr=ReqAddr[i] and WrData=ReqDataA[i] in the next cycle, and remain in IDLE.
REQ-022 SHALL, on an accepted paired request:
  - capture ReqDataB[i] internally;
  - drive WrEn=1, WrAddr=7, WrData=DataA in the next cycle;
  - enter PAIR2;
  - in the following cycle drive WrEn=1, WrAddr=6, WrData=captured DataB;
  - then return to IDLE.
REQ-023 SHALL ignore ReqAddr for paired requests.
REQ-024 SHALL drive WrEn=0 in any cycle that follows no accepted transfer and no PAIR2 second write; WrAddr and WrData then hold their last values.
REQ-025 SHALL permit a new acceptance in the same cycle that the PAIR2 second write is being presented, because the FSM is back in IDLE; back-to-back writes with no bubble are legal.
REQ-026 SHALL require requesters to hold ReqValid, ReqPair, ReqAddr and ReqData stable until accepted; behaviour on a violation is unspecified.
REQ-027 SHALL treat a deasserted ReqValid as a withdrawn request with no side effect.
REQ-028 SHALL keep Busy equal to (state==PAIR2).

Reset
REQ-029 SHALL, while ResetN=0, asynchronously force state=IDLE, WrEn=0, WrAddr=0, WrData=0, Busy=0 and the arbitration pointer to 0.
REQ-030 SHALL, if reset asserts during PAIR2, abandon the register-6 write; no write occurs after release until a new acceptance.
REQ-031 SHALL hold ReqReady at 0 while ResetN=0.

Configuration
REQ-032 SHALL use macro REGFILE_ARB_RR_EN.
REQ-033 SHALL, with REGFILE_ARB_RR_EN defined, use round-robin arbitration:
  - a pointer of ceil(log2(NREQ)) bits, reset 0;
  - the search starts at the pointer and wraps modulo NREQ;
  - after each acceptance by requester i, the pointer becomes (i+1) mod NREQ.
REQ-034 SHALL, without REGFILE_ARB_RR_EN, use fixed priority, lowest index wins; the pointer logic SHALL NOT be compiled in.

Verification
REQ-035 SHALL verify a single write: req1 valid, Addr=3, DataA=0x1234 -> Ready[1]=1 that cycle; next cycle WrEn=1, WrAddr=3, WrData=0x1234; then WrEn=0.
REQ-036 SHALL verify a paired write: req0 valid, Pair=1, DataA=0xAAAA, DataB=0x5555 -> cycle+1 writes 7/0xAAAA with Busy=1; cycle+2 writes 6/0x5555; Ready=0 during PAIR2.
REQ-037 SHALL verify a pair followed immediately by a single: req0 pair, then req2 single to Addr=1 held valid -> writes 7, 6, 1 on three consecutive cycles.
REQ-038 SHALL verify arbitration with all three valid singles held for 6 accepts:
  - RR build: grant order 0,1,2,0,1,2;
  - fixed build: 0 wins every cycle.
REQ-039 SHALL verify reset mid-pair: ResetN low in the PAIR2 cycle -> WrEn=0 and Busy=0 immediately; no register-6 write after release.
REQ-040 SHALL verify simultaneous pair and single: req0 pair and req1 single valid, fixed build -> req0 is served first (7, 6), then req1 is written in the third cycle.
